vc_tp_egress_queue: RTL and testbench

//  Read side for domain-labelled register state. Two per-domain queues (domain 0 = L, 1 = H)
//  are filled through a val/rdy enqueue port and drained to one shared val/rdy consumer.
//  The consumer is served under fixed time-division slots so drain timing never depends on
//  the other domain. Sits at a ring-router output, after the per-domain vc_EnResetReg stages.

---
 rtl/vc_tp_egress_queue_if.sv | 24 ++
 rtl/vc_tp_egress_queue.sv | 168 ++++++++++++++++
 tb/tb_vc_tp_egress_queue.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/vc_tp_egress_queue_if.sv
// -----------------------------------------------------------------------------
// vc_tp_egress_queue_if
//   Domain-labelled val/rdy channel used for both sides of the egress queue.
//   The producer of the transfer takes the master modport, the receiver the
//   slave modport.
//
//   domain : security domain the transfer belongs to (0 = L, 1 = H)
//   val    : transfer valid (producer -> receiver)
//   rdy    : transfer ready (receiver -> producer)
//   msg    : payload, p_nbits wide (producer -> receiver)
// -----------------------------------------------------------------------------
interface vc_tp_egress_queue_if #(
  parameter int p_nbits = 32
) ();

  logic               domain;
  logic               val;
  logic               rdy;
  logic [p_nbits-1:0] msg;

  modport master (output domain, output val, output msg, input rdy);
  modport slave  (input domain, input val, input msg, output rdy);

endinterface

// File: rtl/vc_tp_egress_queue.sv
// -----------------------------------------------------------------------------
// vc_tp_egress_queue
//   Read side for domain-labelled register state. Two per-domain FIFOs
//   (domain 0 = L, domain 1 = H) are filled from one enqueue channel and
//   drained to one shared consumer. The consumer is granted to the domains
//   in fixed time-division slots of p_slot_cycles cycles each, so the drain
//   timing of one domain never depends on the other domain's traffic.
//
//   Parameters
//     p_nbits        payload width in bits
//     p_depth        entries per domain queue (power of two, >= 2)
//     p_slot_cycles  cycles per time slot (>= 2)
//
//   Ports
//     clk    in   clock
//     reset  in   synchronous, active-high reset
//     enq    slave  enqueue channel; enq.rdy depends only on enq.domain
//     deq    master dequeue channel; deq.domain is the current slot owner
//     occ0   out  domain-0 occupancy (0..p_depth)
//     occ1   out  domain-1 occupancy (0..p_depth)
//
//   Configuration
//     TP_EGRESS_DEAD_CYCLE_EN  when defined, the last cycle of every slot is
//                              dead (deq.val = 0) so no transfer straddles a
//                              domain switch. Undefined: every cycle usable.
// -----------------------------------------------------------------------------
module vc_tp_egress_queue #(
  parameter int p_nbits       = 32,
  parameter int p_depth       = 2,
  parameter int p_slot_cycles = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  vc_tp_egress_queue_if.slave      enq,
  vc_tp_egress_queue_if.master     deq,
  output logic [$clog2(p_depth):0] occ0,
  output logic [$clog2(p_depth):0] occ1
);

  localparam int PTR_W = $clog2(p_depth);
  localparam int OCC_W = PTR_W + 1;
  localparam int CNT_W = $clog2(p_slot_cycles);

  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(p_depth);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(p_slot_cycles - 1);

  typedef enum logic {
    SLOT0 = 1'b0,
    SLOT1 = 1'b1
  } slot_e;

  // Slot FSM
  slot_e            state;
  logic [CNT_W-1:0] slot_cnt;

  // Per-domain queue state
  logic [p_nbits-1:0] mem  [2][p_depth];
  logic [PTR_W-1:0]   head [2];
  logic [PTR_W-1:0]   tail [2];
  logic [OCC_W-1:0]   occ  [2];

  logic [1:0] full;
  logic [1:0] empty;
  logic [1:0] enq_sel;   // one-hot: which queue accepts an entry this cycle
  logic [1:0] deq_sel;   // one-hot: which queue releases an entry this cycle
  logic       owner;
  logic       slot_open;
  logic       enq_fire;
  logic       deq_fire;

  // ---------------------------------------------------------------------------
  // Status decode. Full/empty come from registered occupancy only, so a full
  // queue refuses an enqueue even while it is being drained in the same cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int d = 0; d < 2; d++) begin
      full[d]  = (occ[d] == OCC_FULL);
      empty[d] = (occ[d] == '0);
    end
  end

  assign owner = state;

`ifdef TP_EGRESS_DEAD_CYCLE_EN
  assign slot_open = (slot_cnt != CNT_LAST);
`else
  assign slot_open = 1'b1;
`endif

  // Enqueue side: ready looks only at the addressed domain's queue.
  assign enq.rdy  = !reset && !full[enq.domain];
  assign enq_fire = enq.val && enq.rdy;
  assign enq_sel  = !enq_fire ? 2'b00 : (enq.domain ? 2'b10 : 2'b01);

  // Dequeue side: only the slot owner is ever looked at; an empty owner
  // simply idles the consumer rather than letting the other domain through.
  assign deq.domain = owner;
  assign deq.val    = !reset && !empty[owner] && slot_open;
  assign deq.msg    = deq.val ? mem[owner][head[owner]] : '0;
  assign deq_fire   = deq.val && deq.rdy;
  assign deq_sel    = !deq_fire ? 2'b00 : (owner ? 2'b10 : 2'b01);

  assign occ0 = occ[0];
  assign occ1 = occ[1];

  // ---------------------------------------------------------------------------
  // Slot FSM: free-running, advanced by nothing but time and reset.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block or statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= SLOT0;
      slot_cnt <= '0;
    end else if (slot_cnt == CNT_LAST) begin
      slot_cnt <= '0;
      state    <= (state == SLOT0) ? SLOT1 : SLOT0;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Pointers and occupancy. Pointers wrap naturally at p_depth (power of two).
  // Simultaneous enq and deq on one queue moves both pointers, occ unchanged.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int d = 0; d < 2; d++) begin
        head[d] <= '0;
        tail[d] <= '0;
        occ[d]  <= '0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (enq_sel[d]) tail[d] <= tail[d] + 1'b1;
        if (deq_sel[d]) head[d] <= head[d] + 1'b1;
        case ({enq_sel[d], deq_sel[d]})
          2'b10:   occ[d] <= occ[d] + 1'b1;
          2'b01:   occ[d] <= occ[d] - 1'b1;
          default: occ[d] <= occ[d];
        endcase
      end
    end
  end

  // NOTE: the payload array has no reset; occupancy alone decides which
  // entries are meaningful, and deq.msg is forced to zero when not valid.
  always_ff @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (enq_sel[d]) mem[d][tail[d]] <= enq.msg;
    end
  end

  // ---------------------------------------------------------------------------
  // Run-time checks (ignored by synthesis).
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!$isunknown(enq.val));
      assert (!$isunknown(deq.rdy));
      assert (!$isunknown(enq.domain));
      assert (occ[0] <= OCC_FULL);
      assert (occ[1] <= OCC_FULL);
    end
  end

endmodule

// File: tb/tb_vc_tp_egress_queue.sv
// -----------------------------------------------------------------------------
// tb_vc_tp_egress_queue
//   Self-checking bench for vc_tp_egress_queue (p_depth = 2, p_slot_cycles = 4).
//   Expected payloads are pushed into per-domain scoreboard queues when an
//   enqueue is accepted and popped when the consumer takes an entry. A small
//   slot-counter model supplies expected deq_domain / deq_val timing.
//   Inputs are driven and outputs sampled just after the falling edge.
// -----------------------------------------------------------------------------
module tb_vc_tp_egress_queue;

  localparam int NB    = 32;
  localparam int DEPTH = 2;
  localparam int SLOTC = 4;

  logic       clk;
  logic       reset;
  logic [1:0] occ0;
  logic [1:0] occ1;

  vc_tp_egress_queue_if #(.p_nbits(NB)) enq_if ();
  vc_tp_egress_queue_if #(.p_nbits(NB)) deq_if ();

  vc_tp_egress_queue #(
    .p_nbits      (NB),
    .p_depth      (DEPTH),
    .p_slot_cycles(SLOTC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .enq  (enq_if),
    .deq  (deq_if),
    .occ0 (occ0),
    .occ1 (occ1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboards and slot model
  logic [NB-1:0] sb0[$];
  logic [NB-1:0] sb1[$];
  int            m_cnt;
  logic          m_dom;
  int            deq_count;

  task automatic check(input string tag, input logic [NB-1:0] got, input logic [NB-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic model_open();
`ifdef TP_EGRESS_DEAD_CYCLE_EN
    return (m_cnt != SLOTC - 1);
`else
    return 1'b1;
`endif
  endfunction

  // One clock cycle of normal operation: drive, compare, update model.
  task automatic cycle(input logic ev, input logic ed, input logic [NB-1:0] em, input logic dr);
    logic          x_rdy;
    logic          x_val;
    logic [NB-1:0] x_msg;
    int            own_size;
    @(negedge clk);
    reset         = 1'b0;
    enq_if.val    = ev;
    enq_if.domain = ed;
    enq_if.msg    = em;
    deq_if.rdy    = dr;
    #1;
    x_rdy    = ((ed ? sb1.size() : sb0.size()) < DEPTH);
    own_size = m_dom ? sb1.size() : sb0.size();
    x_val    = (own_size != 0) && model_open();
    x_msg    = !x_val ? '0 : (m_dom ? sb1[0] : sb0[0]);
    check("enq_rdy",    NB'(enq_if.rdy),    NB'(x_rdy));
    check("deq_domain", NB'(deq_if.domain), NB'(m_dom));
    check("deq_val",    NB'(deq_if.val),    NB'(x_val));
    check("deq_msg",    deq_if.msg,         x_msg);
    check("occ0",       NB'(occ0),          NB'(sb0.size()));
    check("occ1",       NB'(occ1),          NB'(sb1.size()));
    if (deq_if.val && deq_if.rdy) deq_count++;
    if (x_val && dr) begin
      if (m_dom) void'(sb1.pop_front());
      else       void'(sb0.pop_front());
    end
    if (ev && x_rdy) begin
      if (ed) sb1.push_back(em);
      else    sb0.push_back(em);
    end
    if (m_cnt == SLOTC - 1) begin
      m_cnt = 0;
      m_dom = ~m_dom;
    end else begin
      m_cnt++;
    end
  endtask

  // Reset cycles with enqueue/dequeue activity that must have no effect.
  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset         = 1'b1;
      enq_if.val    = 1'b1;
      enq_if.domain = i[0];
      enq_if.msg    = 32'hDEAD_0000 + i;
      deq_if.rdy    = 1'b1;
      #1;
      check("rst_enq_rdy", NB'(enq_if.rdy), '0);
      check("rst_deq_val", NB'(deq_if.val), '0);
      check("rst_deq_msg", deq_if.msg,      '0);
    end
    sb0.delete();
    sb1.delete();
    m_cnt = 0;
    m_dom = 1'b0;
  endtask

  initial begin
    int exp_deq;
    reset         = 1'b1;
    enq_if.val    = 1'b0;
    enq_if.domain = 1'b0;
    enq_if.msg    = '0;
    deq_if.rdy    = 1'b0;
    m_cnt         = 0;
    m_dom         = 1'b0;
    deq_count     = 0;

    // 1. Reset for two cycles, then check the idle state and enq_rdy.
    do_reset(2);
    cycle(1'b0, 1'b0, '0, 1'b1);            // cycle 0
    check("t1_occ0", NB'(occ0), '0);
    check("t1_deq_domain", NB'(deq_if.domain), '0);
    check("t1_enq_rdy", NB'(enq_if.rdy), 32'd1);

    // 2. 0xA, 0xB to domain 0 in cycles 1-2, drained in SLOT0.
    cycle(1'b1, 1'b0, 32'hA, 1'b1);         // cycle 1
    cycle(1'b1, 1'b0, 32'hB, 1'b1);         // cycle 2: 0xA out
    check("t2_msg_a", deq_if.msg, 32'hA);
    cycle(1'b0, 1'b0, '0, 1'b1);            // cycle 3: 0xB out (unless dead)
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, '0, 1'b1);
    check("t2_occ0_empty", NB'(occ0), '0);

    // 3. 0xC to domain 1 at cycle 0; nothing until SLOT1 at cycle 4.
    do_reset(1);
    cycle(1'b1, 1'b1, 32'hC, 1'b1);         // cycle 0
    for (int i = 1; i < 4; i++) begin
      cycle(1'b0, 1'b0, '0, 1'b1);
      check("t3_no_steal", NB'(deq_if.val), '0);
    end
    cycle(1'b0, 1'b0, '0, 1'b1);            // cycle 4
    check("t3_val",    NB'(deq_if.val), 32'd1);
    check("t3_msg",    deq_if.msg, 32'hC);
    check("t3_domain", NB'(deq_if.domain), 32'd1);

    // 4. Fill domain 0; domain 1 still accepts 0xD.
    do_reset(1);
    cycle(1'b1, 1'b0, 32'h10, 1'b0);
    cycle(1'b1, 1'b0, 32'h11, 1'b0);
    cycle(1'b1, 1'b0, 32'h12, 1'b0);        // refused: full
    check("t4_full_rdy", NB'(enq_if.rdy), '0);
    cycle(1'b1, 1'b1, 32'hD, 1'b0);
    check("t4_other_rdy", NB'(enq_if.rdy), 32'd1);
    cycle(1'b0, 1'b0, '0, 1'b0);
    check("t4_occ1", NB'(occ1), 32'd1);
    check("t4_occ0", NB'(occ0), 32'd2);

    // Full queue draining in the same cycle still refuses the enqueue.
    // Bench is now at cycle 5 (SLOT1); fill domain 0 then stream in SLOT0.
    cycle(1'b0, 1'b0, '0, 1'b0);            // 5
    cycle(1'b0, 1'b0, '0, 1'b0);            // 6
    cycle(1'b0, 1'b0, '0, 1'b0);            // 7

    // 5. Keep domain 0 fed through a whole SLOT0 (cycles 8-11), count drains.
    deq_count = 0;
    for (int i = 0; i < SLOTC; i++) begin
      cycle(1'b1, 1'b0, 32'h50 + i, 1'b1);
      if (i == 0) check("t5_full_refuse", NB'(enq_if.rdy), '0);
    end
`ifdef TP_EGRESS_DEAD_CYCLE_EN
    exp_deq = SLOTC - 1;
`else
    exp_deq = SLOTC;
`endif
    check("t5_slot_drains", NB'(deq_count), NB'(exp_deq));

    // 6. Reset with occ0=2, occ1=1 discards everything.
    do_reset(1);
    cycle(1'b1, 1'b0, 32'h60, 1'b0);
    cycle(1'b1, 1'b0, 32'h61, 1'b0);
    cycle(1'b1, 1'b1, 32'h62, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b0);
    check("t6_pre_occ0", NB'(occ0), 32'd2);
    check("t6_pre_occ1", NB'(occ1), 32'd1);
    do_reset(1);
    cycle(1'b0, 1'b0, '0, 1'b1);
    check("t6_occ0", NB'(occ0), '0);
    check("t6_occ1", NB'(occ1), '0);
    check("t6_val",  NB'(deq_if.val), '0);
    check("t6_dom",  NB'(deq_if.domain), '0);

    // Random traffic with occasional mid-stream reset.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(99) == 0) do_reset(1);
      cycle(1'($urandom_range(1)), 1'($urandom_range(1)), $urandom(),
            ($urandom_range(3) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
